syn_cnt_ctrl: RTL and testbench

- Sequencing controller for a T-flip-flop synchronous up-counter of REG_SIZE bits.
- Drives the counter's enable and clear inputs and watches its q output against a programmable terminal count (TC).
- Supports one-shot and periodic runs, with pause/resume and abort.
- Sits between the host/control logic and a counter instance. The counter stays a pure datapath; this block owns all sequencing.

---
 rtl/syn_cnt_ctrl_pkg.sv | 24 ++
 rtl/syn_cnt_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_syn_cnt_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/syn_cnt_ctrl_pkg.sv
// Shared definitions for the synchronous-counter sequencing controller.
//   - state encoding for the controller FSM
//   - run-mode encodings and a small state-decode helper
package syn_cnt_ctrl_pkg;

  // Controller states. The encoding is fixed because software-visible debug
  // taps and the bench both refer to these numeric values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  // Run mode, captured when a run is started from IDLE.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // A run is in progress in every state except IDLE.
  function automatic logic state_is_busy(input state_e s);
    return (s != IDLE);
  endfunction

endpackage : syn_cnt_ctrl_pkg

// File: rtl/syn_cnt_ctrl.sv
// Sequencing controller for a T-flip-flop synchronous up-counter.
//   Drives the counter's enable / active-low clear and compares its q output
//   against a programmable terminal count (TC). One-shot or periodic runs,
//   with pause (stop), resume (start) and abort. Outputs are a Moore decode of
//   the state plus the live cnt_q compare; there are no output registers.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset; also forces cnt_clr_n low
//   start      start a run from IDLE / resume from PAUSE
//   stop       pause a running count (counter value held)
//   abort      end any run, return to IDLE, clear the counter
//   mode       0 = one-shot, 1 = periodic (sampled on start from IDLE)
//   tc_load    load tc_in into the TC register (IDLE only)
//   tc_in      terminal count value
//   cnt_q      current counter value
//   cnt_en     counter enable
//   cnt_clr_n  counter clear, active-low
//   busy       high in CLEAR / RUN / PAUSE
//   done       one-cycle pulse when the terminal count is reached
//   irq        sticky interrupt, set the cycle after done
//   irq_clr    clears irq
//
// Build option: define SYN_CNT_CTRL_IRQ_EN to build the sticky irq flag.
// Without it irq is tied low and irq_clr is ignored.
//
// Command priority within a cycle: abort > stop > start. tc_load is
// independent of the commands but only has effect in IDLE.
module syn_cnt_ctrl
  import syn_cnt_ctrl_pkg::*;
#(
  parameter int REG_SIZE = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                stop,
  input  logic                abort,
  input  logic                mode,
  input  logic                tc_load,
  input  logic [REG_SIZE-1:0] tc_in,
  input  logic [REG_SIZE-1:0] cnt_q,
  output logic                cnt_en,
  output logic                cnt_clr_n,
  output logic                busy,
  output logic                done,
  output logic                irq,
  input  logic                irq_clr
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [REG_SIZE-1:0] tc_q, tc_d;
  logic                mode_q, mode_d;

  // Counter-clear request from the FSM; combined with the reset below.
  logic                clr_req;

  // ">=" rather than "==" so that a counter that somehow sits above TC
  // still terminates the run instead of wrapping round forever.
  logic                hit;
  assign hit = (cnt_q >= tc_q);

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      tc_q    <= '1;
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      mode_q  <= mode_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    mode_d  = mode_q;
    cnt_en  = 1'b0;
    clr_req = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // TC is only writable between runs so it stays stable for a run.
        // A load coinciding with start is captured here and therefore
        // already in effect when the first RUN compare happens.
        if (tc_load) begin
          tc_d = tc_in;
        end
        if (start && !stop && !abort) begin
          mode_d  = mode;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        // One cycle of synchronous clear so the counter reads 0 in the
        // first RUN cycle.
        clr_req = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          // No done pulse on abort, even if the compare hits this cycle.
          clr_req = 1'b1;
          state_d = IDLE;
        end else if (stop) begin
          // stop beats hit: the terminal count is re-detected on resume.
          state_d = PAUSE;
        end else if (hit) begin
          done    = 1'b1;
          state_d = (mode_q == MODE_PERIODIC) ? CLEAR : IDLE;
        end else begin
          cnt_en  = 1'b1;
        end
      end

      PAUSE: begin
        // Counter frozen and compare ignored until resumed or aborted.
        if (abort) begin
          clr_req = 1'b1;
          state_d = IDLE;
        end else if (!stop && start) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset holds the counter cleared without waiting for a clock edge in
  // the controller; the counter itself samples this on its own clock.
  assign cnt_clr_n = clr & ~clr_req;
  assign busy      = state_is_busy(state_q);

  // ---------------------------------------------------------------------
  // Optional sticky interrupt
  // ---------------------------------------------------------------------
`ifdef SYN_CNT_CTRL_IRQ_EN
  logic irq_q, irq_d;

  // Set has priority over clear so a done can never be lost.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) begin
      irq_d = 1'b0;
    end
    if (done) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule : syn_cnt_ctrl

// File: tb/tb_syn_cnt_ctrl.sv
// Closed-loop bench: controller driving a T-flip-flop synchronous counter.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// Cycle numbering: the cycle in which start is high is cycle 0.
module tb_syn_cnt_ctrl;

  localparam int W = 4;

`ifdef SYN_CNT_CTRL_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         start, stop, abort, mode, tc_load, irq_clr;
  logic [W-1:0] tc_in;
  logic [W-1:0] cnt_q;
  logic         cnt_en, cnt_clr_n, busy, done, irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  syn_cnt_ctrl #(.REG_SIZE(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .abort     (abort),
    .mode      (mode),
    .tc_load   (tc_load),
    .tc_in     (tc_in),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .busy      (busy),
    .done      (done),
    .irq       (irq),
    .irq_clr   (irq_clr)
  );

  // T-flip-flop counter: bit i toggles when enabled and all lower bits are 1.
  function automatic logic [W-1:0] tff_next(input logic [W-1:0] q, input logic en);
    logic         t;
    logic [W-1:0] r;
    t = en;
    for (int i = 0; i < W; i++) begin
      r[i] = q[i] ^ t;
      t    = t & q[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!cnt_clr_n) cnt_q <= '0;
    else            cnt_q <= tff_next(cnt_q, cnt_en);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle 1.
  task automatic pulse_start(input logic m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_tc(input logic [W-1:0] v);
    tc_in   = v;
    tc_load = 1'b1;
    tick();
    tc_load = 1'b0;
  endtask

  // Advance until done is seen (bounded); cyc is the cycle number of done.
  task automatic wait_done(input int c0, output int cyc, output logic [W-1:0] q_at);
    cyc = c0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    q_at = cnt_q;
  endtask

  int           cyc;
  logic [W-1:0] q_at;
  int           ndone;
  int           first_done;
  logic         busy_drop;

  initial begin
    clr = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; mode = 1'b0;
    tc_load = 1'b0; irq_clr = 1'b0; tc_in = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  done, 0);
    check_eq("rst_en",    cnt_en, 0);
    check_eq("rst_clr_n", cnt_clr_n, 0);
    check_eq("rst_irq",   irq, 0);
    clr = 1'b1;
    tick();
    check_eq("post_rst_cnt",   cnt_q, 0);
    check_eq("post_rst_clr_n", cnt_clr_n, 1);

    // ---------------- one-shot tc=5, tc_load during RUN ignored ----------------
    load_tc(4'd5);
    pulse_start(1'b0);                       // cycle 1: CLEAR
    check_eq("os_clear_clr_n", cnt_clr_n, 0);
    check_eq("os_clear_en",    cnt_en, 0);
    check_eq("os_clear_busy",  busy, 1);
    tick();                                  // cycle 2: first RUN
    check_eq("os_run0_cnt", cnt_q, 0);
    check_eq("os_run0_en",  cnt_en, 1);
    tc_in = 4'd2; tc_load = 1'b1;
    tick();                                  // cycle 3
    tc_load = 1'b0;
    wait_done(3, cyc, q_at);
    check_eq("os_done_cyc", cyc, 7);
    check_eq("os_done_cnt", q_at, 5);
    check_eq("os_done_en",  cnt_en, 0);
    tick();
    check_eq("os_idle_busy", busy, 0);
    check_eq("os_idle_done", done, 0);
    tick(); tick();
    check_eq("os_idle_hold", cnt_q, 5);

    // ---------------- reset mid-run ----------------
    pulse_start(1'b0);
    tick(); tick(); tick(); tick();          // cycle 5
    check_eq("mr_cnt_before", cnt_q, 3);
    clr = 1'b0;
    #1;
    check_eq("mr_clr_n", cnt_clr_n, 0);
    check_eq("mr_en",    cnt_en, 0);
    check_eq("mr_busy",  busy, 0);
    tick(); tick();
    clr = 1'b1;
    tick();
    check_eq("mr_cnt_after", cnt_q, 0);
    check_eq("mr_busy_after", busy, 0);

    // ---------------- tc back to all-ones: tc=15, no wrap ----------------
    pulse_start(1'b0);
    wait_done(1, cyc, q_at);
    check_eq("tc15_done_cyc", cyc, 17);
    check_eq("tc15_done_cnt", q_at, 15);
    tick();
    check_eq("tc15_idle_cnt",  cnt_q, 15);
    check_eq("tc15_idle_busy", busy, 0);

    // ---------------- tc_load + start same cycle ----------------
    tc_in = 4'd2; tc_load = 1'b1; mode = 1'b0; start = 1'b1;
    tick();
    tc_load = 1'b0; start = 1'b0;
    wait_done(1, cyc, q_at);
    check_eq("ldst_done_cyc", cyc, 4);
    check_eq("ldst_done_cnt", q_at, 2);
    tick();

    // ---------------- tc=0 ----------------
    load_tc(4'd0);
    pulse_start(1'b0);
    wait_done(1, cyc, q_at);
    check_eq("tc0_done_cyc", cyc, 2);
    check_eq("tc0_done_cnt", q_at, 0);
    tick();

    // ---------------- periodic tc=3, abort on a hit cycle ----------------
    load_tc(4'd3);
    pulse_start(1'b1);
    ndone = 0; first_done = 0; busy_drop = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      if (busy !== 1'b1) busy_drop = 1'b1;
      tick();
    end                                      // now cycle 25
    check_eq("per_ndone",      ndone, 4);
    check_eq("per_first_done", first_done, 5);
    check_eq("per_busy_drop",  busy_drop, 0);
    check_eq("per_cnt25",      cnt_q, 3);
    abort = 1'b1;
    #1;
    check_eq("abort_no_done", done, 0);
    check_eq("abort_clr_n",   cnt_clr_n, 0);
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_cnt",  cnt_q, 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check_eq("abort_quiet", ndone, 0);

    // ---------------- pause / resume tc=9 ----------------
    load_tc(4'd9);
    pulse_start(1'b0);
    for (int c = 0; c < 5; c++) tick();     // cycle 6
    check_eq("pz_cnt6", cnt_q, 4);
    stop = 1'b1;
    #1;
    check_eq("pz_stop_en", cnt_en, 0);
    tick();                                  // cycle 7: PAUSE
    stop = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      check_eq("pz_hold_cnt", cnt_q, 4);
      check_eq("pz_hold_en",  cnt_en, 0);
      tick();
    end                                      // cycle 11
    check_eq("pz_busy", busy, 1);
    start = 1'b1;
    tick();                                  // cycle 12: RUN again
    start = 1'b0;
    check_eq("pz_resume_cnt", cnt_q, 4);
    wait_done(12, cyc, q_at);
    check_eq("pz_done_cyc", cyc, 17);
    check_eq("pz_done_cnt", q_at, 9);
    tick();

    // ---------------- stop coincident with hit ----------------
    pulse_start(1'b0);
    for (int c = 0; c < 10; c++) tick();    // cycle 11
    check_eq("sh_cnt", cnt_q, 9);
    stop = 1'b1;
    #1;
    check_eq("sh_no_done", done, 0);
    tick();                                  // cycle 12: PAUSE
    stop = 1'b0;
    check_eq("sh_pause_done", done, 0);
    check_eq("sh_pause_busy", busy, 1);
    tick(); tick();                          // cycle 14
    check_eq("sh_pause_cnt", cnt_q, 9);
    check_eq("sh_pause_done2", done, 0);
    start = 1'b1;
    tick();                                  // cycle 15: RUN, hit again
    start = 1'b0;
    check_eq("sh_resume_done", done, 1);
    check_eq("sh_resume_en",   cnt_en, 0);
    tick();
    check_eq("sh_idle_busy", busy, 0);

    // ---------------- irq ----------------
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_eq("irq_cleared0", irq, 0);
    load_tc(4'd0);
    pulse_start(1'b0);
    tick();                                  // cycle 2
    check_eq("irq_done",     done, 1);
    check_eq("irq_not_yet",  irq, 0);
    tick();
    check_eq("irq_set",      irq, IRQ_EXP);
    tick(); tick();
    check_eq("irq_hold",     irq, IRQ_EXP);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_eq("irq_clr", irq, 0);
    pulse_start(1'b0);
    tick(); tick();
    check_eq("irq_set2", irq, IRQ_EXP);
    pulse_start(1'b0);
    tick();                                  // done cycle with irq_clr
    check_eq("irq_done3", done, 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_eq("irq_set_wins", irq, IRQ_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule : tb_syn_cnt_ctrl
